// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of the two-digit hex display
// with a minimum on-screen hold per grant and blanking when idle.
module disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned TURBO_HOLD  = 3_125_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic       turbo_mode,
  output logic [7:0] disp_data,
  output logic       disp_enable,
  output logic [2:0] grant,
  output logic [1:0] src
);

  localparam int unsigned MAXH =
    (HOLD_CYCLES > TURBO_HOLD) ? HOLD_CYCLES : TURBO_HOLD;
  localparam int CW = $clog2(MAXH) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {IDLE, SHOW} state_t;

  localparam cnt_t LIM_N = cnt_t'(HOLD_CYCLES);
  localparam cnt_t LIM_T = cnt_t'(TURBO_HOLD);

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [1:0] src_q, src_d;
  logic [7:0] data_q, data_d;

  cnt_t       lim;
  logic [CW:0] cnt_inc;
  logic       expired;
  logic [1:0] win;

  function automatic logic [7:0] pick(
    input logic [1:0] k,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    unique case (k)
      2'd1:    return b;
      2'd2:    return c;
      default: return a;
    endcase
  endfunction

  always_comb begin
    lim     = turbo_mode ? LIM_T : LIM_N;
    cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    expired = cnt_inc >= {1'b0, lim};
  end

  // Search starts one past the previous winner, modulo 3.
  always_comb begin
    win = 2'd0;
    unique case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    src_d   = src_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SHOW;
          src_d   = win;
          last_d  = win;
          cnt_d   = '0;
          data_d  = pick(win, data0, data1, data2);
        end
      end
      SHOW: begin
        if (!expired) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (req[src_q])
            data_d = pick(src_q, data0, data1, data2);
        end else if (|req) begin
          src_d  = win;
          last_d = win;
          cnt_d  = '0;
          data_d = pick(win, data0, data1, data2);
        end else begin
          state_d = IDLE;
          src_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      src_q   <= 2'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  assign disp_enable = (state_q == SHOW);
  assign src         = src_q;
  assign disp_data   = data_q;
  assign grant       = disp_enable ? (3'b001 << src_q) : 3'b000;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: vector table plus directed multi-cycle
// sequences with HOLD_CYCLES = 8 and TURBO_HOLD = 2.
module tb_disp_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] d0, d1, d2;
  logic       turbo;
  logic [7:0] disp_data;
  logic       disp_enable;
  logic [2:0] grant;
  logic [1:0] src;

  int checks = 0;
  int errors = 0;

  disp_arbiter #(
    .HOLD_CYCLES(8),
    .TURBO_HOLD (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (d0),
    .data1      (d1),
    .data2      (d2),
    .turbo_mode (turbo),
    .disp_data  (disp_data),
    .disp_enable(disp_enable),
    .grant      (grant),
    .src        (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] g;
    logic [1:0] s;
    logic       en;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm,
                            input logic [2:0] g,
                            input logic [1:0] s,
                            input logic en,
                            input logic [7:0] d);
    chk({nm, ".grant"}, 8'(grant), 8'(g));
    chk({nm, ".src"}, 8'(src), 8'(s));
    chk({nm, ".en"}, 8'(disp_enable), 8'(en));
    chk({nm, ".data"}, disp_data, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    turbo = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [2:0] tg[6];
    rst_n = 1'b0;
    req   = 3'b000;
    turbo = 1'b0;
    d0    = 8'h12;
    d1    = 8'h34;
    d2    = 8'h56;

    tbl[0] = '{1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 3'b111, 3'b001, 2'd0, 1'b1, 8'h12};
    tbl[3] = '{1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 3'b010, 3'b010, 2'd1, 1'b1, 8'h34};
    tbl[5] = '{1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 3'b100, 3'b100, 2'd2, 1'b1, 8'h56};

    for (int i = 0; i < 7; i++) begin
      rst_n = tbl[i].rst;
      req   = tbl[i].req;
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].g,
                 tbl[i].s, tbl[i].en, tbl[i].d);
    end

    // round robin, 8-cycle tenures, no blank gap
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 32; i++) begin
      step();
      k = (i / 8) % 3;
      expect_out($sformatf("rr%0d", i), 3'b001 << k,
                 2'(k), 1'b1,
                 (k == 0) ? 8'h12 : (k == 1) ? 8'h34 : 8'h56);
    end

    // live tracking then freeze after req drop
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d0  = 8'(i);
      req = (i < 4) ? 3'b001 : 3'b000;
      step();
      expect_out($sformatf("live%0d", i),
                 (i < 8) ? 3'b001 : 3'b000, 2'd0,
                 (i < 8), (i < 4) ? 8'(i) : 8'h03);
    end

    // sole requester is re-granted with counter restart
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      d1 = 8'(i + 64);
      step();
      expect_out($sformatf("sole%0d", i), 3'b010, 2'd1,
                 1'b1, 8'(i + 64));
      chk($sformatf("sole%0d.cnt", i), 8'(dut.cnt_q), 8'(i % 8));
    end

    // turbo asserted at cnt = 5 forces handover
    d0 = 8'h12;
    d1 = 8'h34;
    do_reset();
    req = 3'b011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("tpre%0d.grant", i), 8'(grant), 8'h01);
      chk($sformatf("tpre%0d.cnt", i), 8'(dut.cnt_q), 8'(i));
    end
    turbo = 1'b1;
    tg = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010};
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("turbo%0d.grant", i), 8'(grant), 8'(tg[i]));
      chk($sformatf("turbo%0d.cnt", i), 8'(dut.cnt_q), 8'(i % 2));
      chk($sformatf("turbo%0d.en", i), 8'(disp_enable), 8'h01);
    end
    turbo = 1'b0;

    // reset in the middle of source 2's tenure
    d2 = 8'h56;
    do_reset();
    req = 3'b100;
    for (int i = 0; i < 4; i++) step();
    chk("mid.grant", 8'(grant), 8'h04);
    chk("mid.cnt", 8'(dut.cnt_q), 8'h03);
    rst_n = 1'b0;
    req   = 3'b111;
    step();
    expect_out("midrst", 3'b000, 2'd0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    expect_out("midrel", 3'b001, 2'd0, 1'b1, 8'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
